app_line_buffer: RTL and testbench



---
 rtl/app_line_buffer.sv | 126 ++++++++++++
 tb/tb_app_line_buffer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/app_line_buffer.sv
// rtl/app_line_buffer.sv - CDC line buffer: collects an OUT line, optionally upcases it, returns it on IN.
// Echoes the line on EOL or when full; an EOL-terminated line is followed by LF.
module app_line_buffer #(
  parameter int         DEPTH  = 64,
  parameter logic [7:0] EOL    = 8'h0D,
  parameter bit         UPCASE = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] out_data_i,
  input  logic       out_valid_i,
  output logic       out_ready_o,
  output logic [7:0] in_data_o,
  output logic       in_valid_o,
  input  logic       in_ready_i
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_LF    = 2'd3;

  localparam logic [AW-1:0] C_PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   C_CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   C_FULL    = DEPTH[AW:0];

  logic [1:0]    r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_eol_flag;
  logic [7:0]    r_mem [DEPTH];

  logic          w_accept;
  logic          w_send;
  logic          w_last;
  logic [7:0]    w_store;
  logic [AW:0]   w_cnt_inc;

  assign w_accept  = (r_state == S_FILL) && out_valid_i;
  assign w_send    = in_valid_o && in_ready_i;
  assign w_cnt_inc = r_count + C_CNT_ONE;
  assign w_last    = ({1'b0, r_rd_ptr} + C_CNT_ONE) == r_count;

  always_comb begin
    w_store = out_data_i;
    if (UPCASE && (out_data_i >= 8'h61) && (out_data_i <= 8'h7A)) begin
      w_store = out_data_i - 8'h20;
    end
  end

  assign out_ready_o = (r_state == S_FILL);
  assign in_valid_o  = (r_state == S_DRAIN) || (r_state == S_LF);

  always_comb begin
    case (r_state)
      S_DRAIN: in_data_o = r_mem[r_rd_ptr];
      S_LF:    in_data_o = 8'h0A;
      default: in_data_o = 8'h00;
    endcase
  end

  // Buffer contents need no reset; they are only read back below count.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= w_store;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_eol_flag <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FILL;
        end
        S_FILL: begin
          if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            r_count  <= w_cnt_inc;
            // EOL is matched on the raw byte and takes priority over full.
            if (out_data_i == EOL) begin
              r_eol_flag <= 1'b1;
              r_state    <= S_DRAIN;
            end else if (w_cnt_inc == C_FULL) begin
              r_eol_flag <= 1'b0;
              r_state    <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_send) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            if (w_last) begin
              if (r_eol_flag) begin
                r_state <= S_LF;
              end else begin
                r_state  <= S_FILL;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
              end
            end
          end
        end
        default: begin
          if (w_send) begin
            r_state    <= S_FILL;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_eol_flag <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_app_line_buffer.sv
// tb/tb_app_line_buffer.sv - directed bench for app_line_buffer (DEPTH=4, upcase and raw instances).
module tb_app_line_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] out_data = 8'h00;
  logic       out_valid = 1'b0;
  logic       in_ready = 1'b1;

  logic       out_ready, in_valid;
  logic [7:0] in_data;
  logic       out_ready_raw, in_valid_raw;
  logic [7:0] in_data_raw;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  app_line_buffer #(.DEPTH(4), .EOL(8'h0D), .UPCASE(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .out_data_i(out_data), .out_valid_i(out_valid), .out_ready_o(out_ready),
    .in_data_o(in_data), .in_valid_o(in_valid), .in_ready_i(in_ready)
  );

  app_line_buffer #(.DEPTH(4), .EOL(8'h0D), .UPCASE(1'b0)) u_dut_raw (
    .clk_i(clk), .rst_i(rst),
    .out_data_i(out_data), .out_valid_i(out_valid), .out_ready_o(out_ready_raw),
    .in_data_o(in_data_raw), .in_valid_o(in_valid_raw), .in_ready_i(in_ready)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    out_data  = b;
    out_valid = 1'b1;
    while (!out_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("send_%02h_ready", b), {7'd0, out_ready}, 8'd1);
    @(negedge clk);
    out_valid = 1'b0;
  endtask

  // With in_ready held high every output byte must already be presented.
  task automatic recv_byte(input logic [7:0] exp, input logic [7:0] exp_raw);
    in_ready = 1'b1;
    check($sformatf("valid_%02h", exp), {7'd0, in_valid}, 8'd1);
    check($sformatf("data_%02h", exp), in_data, exp);
    check($sformatf("raw_data_%02h", exp_raw), in_data_raw, exp_raw);
    check($sformatf("ready_low_%02h", exp), {7'd0, out_ready}, 8'd0);
    @(negedge clk);
  endtask

  task automatic stall(input int cycles, input logic [7:0] exp);
    in_ready = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("stall_valid", {7'd0, in_valid}, 8'd1);
      check("stall_data", in_data, exp);
    end
  endtask

  initial begin
    #1;
    check("rst_out_ready", {7'd0, out_ready}, 8'd0);
    check("rst_in_valid", {7'd0, in_valid}, 8'd0);
    check("rst_in_data", in_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    check("idle_out_ready", {7'd0, out_ready}, 8'd0);
    @(negedge clk);
    check("fill_out_ready", {7'd0, out_ready}, 8'd1);

    // Line "ab\r" upcased, LF appended, valid the cycle after EOL.
    send_byte(8'h61);
    send_byte(8'h62);
    send_byte(8'h0D);
    check("first_valid_latency", {7'd0, in_valid}, 8'd1);
    recv_byte(8'h41, 8'h61);
    recv_byte(8'h42, 8'h62);
    recv_byte(8'h0D, 8'h0D);
    recv_byte(8'h0A, 8'h0A);
    check("back_to_fill", {7'd0, out_ready}, 8'd1);
    check("no_extra_valid", {7'd0, in_valid}, 8'd0);

    // Full line without EOL: no LF; 0x35 held off until FILL.
    send_byte(8'h31);
    send_byte(8'h32);
    send_byte(8'h33);
    send_byte(8'h34);
    out_data  = 8'h35;
    out_valid = 1'b1;
    recv_byte(8'h31, 8'h31);
    recv_byte(8'h32, 8'h32);
    recv_byte(8'h33, 8'h33);
    recv_byte(8'h34, 8'h34);
    check("full_no_lf", {7'd0, in_valid}, 8'd0);
    send_byte(8'h35);
    send_byte(8'h0D);
    recv_byte(8'h35, 8'h35);
    recv_byte(8'h0D, 8'h0D);
    recv_byte(8'h0A, 8'h0A);

    // Backpressure on line "a\r".
    send_byte(8'h61);
    send_byte(8'h0D);
    stall(5, 8'h41);
    recv_byte(8'h41, 8'h61);
    stall(5, 8'h0D);
    recv_byte(8'h0D, 8'h0D);
    stall(2, 8'h0A);
    recv_byte(8'h0A, 8'h0A);
    check("bp_done", {7'd0, in_valid}, 8'd0);

    // Conversion boundaries; EOL as the DEPTH-th byte still gets LF.
    send_byte(8'h60);
    send_byte(8'h7B);
    send_byte(8'h7A);
    send_byte(8'h0D);
    recv_byte(8'h60, 8'h60);
    recv_byte(8'h7B, 8'h7B);
    recv_byte(8'h5A, 8'h7A);
    recv_byte(8'h0D, 8'h0D);
    recv_byte(8'h0A, 8'h0A);

    // Empty line, then a normal line.
    send_byte(8'h0D);
    recv_byte(8'h0D, 8'h0D);
    recv_byte(8'h0A, 8'h0A);
    send_byte(8'h78);
    send_byte(8'h0D);
    recv_byte(8'h58, 8'h78);
    recv_byte(8'h0D, 8'h0D);
    recv_byte(8'h0A, 8'h0A);

    // Reset mid-DRAIN discards the line.
    send_byte(8'h63);
    send_byte(8'h64);
    send_byte(8'h0D);
    recv_byte(8'h43, 8'h63);
    rst = 1'b1;
    #1;
    check("rst_mid_in_valid", {7'd0, in_valid}, 8'd0);
    check("rst_mid_out_ready", {7'd0, out_ready}, 8'd0);
    check("rst_mid_in_data", in_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_byte(8'h62);
    send_byte(8'h0D);
    recv_byte(8'h42, 8'h62);
    recv_byte(8'h0D, 8'h0D);
    recv_byte(8'h0A, 8'h0A);
    check("post_rst_done", {7'd0, in_valid}, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
